// File: rtl/egg_timer_if.sv
// Button/counter-status inputs and BCD setting/strobe outputs of the egg timer
// control stage, grouped so the controller and its environment share one bundle.
interface egg_timer_if;
    logic       btn_sec;
    logic       btn_min;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       count_zero;
    logic [3:0] seconds_prog;
    logic [3:0] tens_seconds_prog;
    logic [3:0] minutes_prog;
    logic [3:0] tens_minutes_prog;
    logic       load;
    logic       pulse_1s;
    logic       timer_on;
    logic       alarm;

    modport master (
        output btn_sec, btn_min, btn_start_stop, btn_clear, count_zero,
        input  seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
        input  load, pulse_1s, timer_on, alarm
    );

    modport slave (
        input  btn_sec, btn_min, btn_start_stop, btn_clear, count_zero,
        output seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
        output load, pulse_1s, timer_on, alarm
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Egg timer front end: button events -> BCD MM:SS setting + load strobe, 1 s tick,
// run/pause/alarm control. Define EGG_TIMER_AUTO_SILENCE_EN to auto-exit ALARM after ALARM_SECS.
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 30
) (
    input  logic      clk,
    input  logic      reset,
    egg_timer_if.slave bus
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    if (TICK_DIV < 2 || ALARM_SECS < 1) begin : g_bad_params
        $error("egg_timer_ctrl: TICK_DIV must be >= 2 and ALARM_SECS >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    sec_u_q, sec_u_d, sec_t_q, sec_t_d;
    logic [3:0]    min_u_q, min_u_d, min_t_q, min_t_d;
    logic          upd_q, upd_d;
    logic          load_q;
    logic [3:0]    sync1_q, sync2_q, prev_q, evt_q;
    logic [3:0]    btn;
    logic          ev_clr, ev_ss, ev_min, ev_sec, ev_any;
    logic          setting_nz;

`ifdef EGG_TIMER_AUTO_SILENCE_EN
    localparam int            SW       = $clog2(ALARM_SECS + 1);
    localparam logic [SW-1:0] SIL_LAST = SW'(ALARM_SECS - 1);
    localparam logic [SW-1:0] SIL_ONE  = SW'(1);
    logic [SW-1:0] sil_q, sil_d;
`endif

    // Increment a two-digit BCD field, wrapping to 00 after {tens_max,9}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] units,
                                           input logic [3:0] tens_max);
        if (units == 4'd9) begin
            if (tens == tens_max) return 8'h00;
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

    // Bit order throughout: [3]=clear [2]=start_stop [1]=min [0]=sec
    assign btn = {bus.btn_clear, bus.btn_start_stop, bus.btn_min, bus.btn_sec};

    assign ev_clr = evt_q[3];
    assign ev_ss  = evt_q[2] & ~evt_q[3];
    assign ev_min = evt_q[1] & ~(|evt_q[3:2]);
    assign ev_sec = evt_q[0] & ~(|evt_q[3:1]);
    assign ev_any = |evt_q;

    assign setting_nz = |{sec_u_q, sec_t_q, min_u_q, min_t_q};

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        upd_d   = 1'b0;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
        sil_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ev_clr) begin
                    {sec_t_d, sec_u_d, min_t_d, min_u_d} = '0;
                    upd_d = 1'b1;
                end else if (ev_ss) begin
                    if (setting_nz) begin
                        state_d = S_RUN;
                        pre_d   = '0;
                    end
                end else if (ev_min) begin
                    {min_t_d, min_u_d} = bcd_inc(min_t_q, min_u_q, 4'd9);
                    upd_d = 1'b1;
                end else if (ev_sec) begin
                    {sec_t_d, sec_u_d} = bcd_inc(sec_t_q, sec_u_q, 4'd5);
                    upd_d = 1'b1;
                end
            end
            S_RUN: begin
                // Expiry is checked before any button so a racing press cannot mask it.
                if (bus.count_zero) begin
                    state_d = S_ALARM;
                    pre_d   = '0;
                end else if (ev_clr) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    upd_d   = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_PAUSE;
                end else begin
                    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    upd_d   = 1'b1;
                end else if (ev_ss) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (ev_any) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    upd_d   = 1'b1;
                end
`ifdef EGG_TIMER_AUTO_SILENCE_EN
                else begin
                    // Prescaler keeps running here purely to time the auto-silence.
                    sil_d = sil_q;
                    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
                    if (pre_q == PRE_LAST) begin
                        if (sil_q == SIL_LAST) begin
                            state_d = S_IDLE;
                            pre_d   = '0;
                            sil_d   = '0;
                            upd_d   = 1'b1;
                        end else begin
                            sil_d = sil_q + SIL_ONE;
                        end
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            sec_u_q <= '0;
            sec_t_q <= '0;
            min_u_q <= '0;
            min_t_q <= '0;
            upd_q   <= 1'b0;
            load_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            evt_q   <= '0;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
            sil_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
            upd_q   <= upd_d;
            // Load trails the setting update by one cycle so downstream samples settled digits.
            load_q  <= upd_q;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            evt_q   <= sync2_q & ~prev_q;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
            sil_q   <= sil_d;
`endif
        end
    end

    assign bus.seconds_prog      = sec_u_q;
    assign bus.tens_seconds_prog = sec_t_q;
    assign bus.minutes_prog      = min_u_q;
    assign bus.tens_minutes_prog = min_t_q;
    assign bus.load              = load_q;
    assign bus.pulse_1s          = (state_q == S_RUN) && (pre_q == PRE_LAST);
    assign bus.timer_on          = (state_q == S_RUN);
    assign bus.alarm             = (state_q == S_ALARM);

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: a minutes/seconds integer model of the
// setting plus cycle-level checks of tick spacing, pause phase, alarm and reset.
module tb_egg_timer_ctrl;
    localparam int TICK_DIV   = 10;
    localparam int ALARM_SECS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    egg_timer_if bus ();

    egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int load_cnt   = 0;
    int pulse_cnt  = 0;
    int m_sec      = 0;
    int m_min      = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.load)     load_cnt++;
            if (bus.pulse_1s) pulse_cnt++;
        end
    end

    function automatic logic [15:0] exp_bcd();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic [15:0] obs_bcd();
        return {bus.tens_minutes_prog, bus.minutes_prog, bus.tens_seconds_prog, bus.seconds_prog};
    endfunction

    // m = {clear, start_stop, min, sec}; one press of every set bit in the same cycle
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {bus.btn_clear, bus.btn_start_stop, bus.btn_min, bus.btn_sec} = m;
        repeat (3) @(negedge clk);
        {bus.btn_clear, bus.btn_start_stop, bus.btn_min, bus.btn_sec} = 4'b0000;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pulse_1s && n < 40);
    endtask

    task automatic test_reset();
        {bus.btn_clear, bus.btn_start_stop, bus.btn_min, bus.btn_sec} = 4'b0000;
        bus.count_zero = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({obs_bcd(), bus.load, bus.pulse_1s, bus.timer_on, bus.alarm} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h required=00000",
                     {obs_bcd(), bus.load, bus.pulse_1s, bus.timer_on, bus.alarm});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_set_buttons();
        int l0;
        press(4'b1000);
        m_sec = 0; m_min = 0;
        l0 = load_cnt;
        for (int i = 0; i < 61; i++) begin
            press(4'b0001);
            m_sec = (m_sec + 1) % 60;
            vectors++;
            if (obs_bcd() !== exp_bcd()) begin
                miscompares++;
                $display("FAIL sec_step%0d: setting=%h required=%h", i, obs_bcd(), exp_bcd());
            end
        end
        vectors++;
        if (load_cnt - l0 != 61) begin
            miscompares++;
            $display("FAIL sec_loads: got=%0d required=61", load_cnt - l0);
        end
        l0 = load_cnt;
        for (int i = 0; i < 100; i++) begin
            press(4'b0010);
            m_min = (m_min + 1) % 100;
            vectors++;
            if (obs_bcd() !== exp_bcd()) begin
                miscompares++;
                $display("FAIL min_step%0d: setting=%h required=%h", i, obs_bcd(), exp_bcd());
            end
        end
        vectors++;
        if (load_cnt - l0 != 100 || obs_bcd() !== 16'h0001) begin
            miscompares++;
            $display("FAIL min_wrap: loads=%0d setting=%h required 100 / 0001", load_cnt - l0, obs_bcd());
        end
    endtask

    task automatic test_random_idle();
        int l0;
        logic [3:0] m;
        for (int i = 0; i < 40; i++) begin
            m = 4'($urandom_range(1, 7));
            m = {m[2] & ($urandom_range(0, 3) == 0), 1'b0, m[1], m[0]};
            if (m == 4'b0000) m = 4'b0001;
            l0 = load_cnt;
            press(m);
            if (m[3]) begin
                m_sec = 0; m_min = 0;
            end else if (m[1]) begin
                m_min = (m_min + 1) % 100;
            end else begin
                m_sec = (m_sec + 1) % 60;
            end
            vectors++;
            if (obs_bcd() !== exp_bcd() || load_cnt - l0 != 1) begin
                miscompares++;
                $display("FAIL rand_idle%0d mask=%b: setting=%h loads=%0d required=%h / 1",
                         i, m, obs_bcd(), load_cnt - l0, exp_bcd());
            end
        end
    endtask

    task automatic test_start_and_tick();
        int l0, n;
        press(4'b1000);
        m_sec = 0; m_min = 0;
        l0 = load_cnt;
        press(4'b0100);
        vectors++;
        if (bus.timer_on !== 1'b0 || load_cnt != l0) begin
            miscompares++;
            $display("FAIL start_zero: timer_on=%b loads=%0d required 0 / 0", bus.timer_on, load_cnt - l0);
        end
        repeat (3) press(4'b0001);
        m_sec = 3;
        press(4'b0100);
        vectors++;
        if (bus.timer_on !== 1'b1) begin
            miscompares++;
            $display("FAIL start_run: timer_on=%b required=1", bus.timer_on);
        end
        wait_pulse(n);
        for (int k = 0; k < 2; k++) begin
            wait_pulse(n);
            vectors++;
            if (n != TICK_DIV) begin
                miscompares++;
                $display("FAIL tick_gap%0d: cycles=%0d required=%0d", k, n, TICK_DIV);
            end
        end
        l0 = load_cnt;
        press(4'b0011);
        vectors++;
        if (obs_bcd() !== exp_bcd() || load_cnt != l0 || bus.timer_on !== 1'b1) begin
            miscompares++;
            $display("FAIL run_ignores_set: setting=%h loads=%0d on=%b required=%h / 0 / 1",
                     obs_bcd(), load_cnt - l0, bus.timer_on, exp_bcd());
        end
    endtask

    task automatic test_pause_resume();
        int n, p0;
        wait_pulse(n);
        // Pulse marks prescaler = 9; the event lands three edges after the drive,
        // so driving two cycles later makes it sample prescaler = 4.
        repeat (2) @(negedge clk);
        bus.btn_start_stop = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_start_stop = 1'b0;
        repeat (3) @(negedge clk);
        p0 = pulse_cnt;
        repeat (30) @(negedge clk);
        vectors++;
        if (bus.timer_on !== 1'b0 || pulse_cnt != p0) begin
            miscompares++;
            $display("FAIL pause: timer_on=%b pulses=%0d required 0 / 0", bus.timer_on, pulse_cnt - p0);
        end
        bus.btn_start_stop = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 4) bus.btn_start_stop = 1'b0;
        end while (!bus.timer_on && n < 20);
        bus.btn_start_stop = 1'b0;
        vectors++;
        if (!bus.timer_on) begin
            miscompares++;
            $display("FAIL resume_timeout: timer_on=%b required=1", bus.timer_on);
        end
        wait_pulse(n);
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL resume_phase: cycles=%0d required=5", n);
        end
    endtask

    task automatic enter_alarm();
        @(negedge clk);
        bus.count_zero = 1'b1;
        @(negedge clk);
        bus.count_zero = 1'b0;
        vectors++;
        if (bus.alarm !== 1'b1 || bus.timer_on !== 1'b0) begin
            miscompares++;
            $display("FAIL alarm_entry: alarm=%b timer_on=%b required 1 / 0", bus.alarm, bus.timer_on);
        end
    endtask

    task automatic test_alarm_clear();
        int l0;
        enter_alarm();
        l0 = load_cnt;
        press(4'b1000);
        vectors++;
        if (bus.alarm !== 1'b0 || load_cnt - l0 != 1 || obs_bcd() !== exp_bcd()) begin
            miscompares++;
            $display("FAIL alarm_clear: alarm=%b loads=%0d setting=%h required 0 / 1 / %h",
                     bus.alarm, load_cnt - l0, obs_bcd(), exp_bcd());
        end
    endtask

    task automatic test_clear_priority();
        int l0;
        press(4'b0100);
        vectors++;
        if (bus.timer_on !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: timer_on=%b required=1", bus.timer_on);
        end
        l0 = load_cnt;
        press(4'b1100);
        vectors++;
        if (bus.timer_on !== 1'b0 || load_cnt - l0 != 1 || obs_bcd() !== exp_bcd()) begin
            miscompares++;
            $display("FAIL clear_wins: timer_on=%b loads=%0d setting=%h required 0 / 1 / %h",
                     bus.timer_on, load_cnt - l0, obs_bcd(), exp_bcd());
        end
    endtask

    task automatic test_alarm_exit();
        int l0, n;
        press(4'b0100);
        enter_alarm();
        l0 = load_cnt;
`ifdef EGG_TIMER_AUTO_SILENCE_EN
        n = 1;
        forever begin
            @(negedge clk);
            if (!bus.alarm || n >= 100) break;
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (n != ALARM_SECS * TICK_DIV || load_cnt - l0 != 1 || obs_bcd() !== exp_bcd()) begin
            miscompares++;
            $display("FAIL auto_silence: alarm_cycles=%0d loads=%0d setting=%h required %0d / 1 / %h",
                     n, load_cnt - l0, obs_bcd(), ALARM_SECS * TICK_DIV, exp_bcd());
        end
`else
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.alarm) n++;
        end
        vectors++;
        if (n != 50) begin
            miscompares++;
            $display("FAIL alarm_persist: alarm_cycles=%0d required=50", n);
        end
        press(4'b0001);
        vectors++;
        if (bus.alarm !== 1'b0 || load_cnt - l0 != 1 || obs_bcd() !== exp_bcd()) begin
            miscompares++;
            $display("FAIL alarm_btn_exit: alarm=%b loads=%0d setting=%h required 0 / 1 / %h",
                     bus.alarm, load_cnt - l0, obs_bcd(), exp_bcd());
        end
`endif
    endtask

    task automatic test_reset_midrun();
        press(4'b0100);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({obs_bcd(), bus.load, bus.pulse_1s, bus.timer_on, bus.alarm} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_midrun: outputs=%h required=00000",
                     {obs_bcd(), bus.load, bus.pulse_1s, bus.timer_on, bus.alarm});
        end
        @(negedge clk);
        reset = 1'b1;
        m_sec = 0; m_min = 0;
        press(4'b0100);
        vectors++;
        if (bus.timer_on !== 1'b0 || obs_bcd() !== exp_bcd()) begin
            miscompares++;
            $display("FAIL post_reset_idle: timer_on=%b setting=%h required 0 / %h",
                     bus.timer_on, obs_bcd(), exp_bcd());
        end
    endtask

    initial begin
        test_reset();
        test_set_buttons();
        test_random_idle();
        test_start_and_tick();
        test_pause_resume();
        test_alarm_clear();
        test_clear_priority();
        test_alarm_exit();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
